// File: rtl/rr_rsp_router_if.sv
// Handshake bundle between the arbiter/shared resource side and the response router.
// The router takes the slave view; the surrounding logic (or a bench) takes the master view.
interface rr_rsp_router_if #(
   parameter int REQ_NUM = 7,
   parameter int DATA_W  = 32
);
   logic [REQ_NUM-1:0] grant;
   logic               grant_fire;
   logic               id_full;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [DATA_W-1:0]  rsp_data;
   logic [REQ_NUM-1:0] out_valid;
   logic [REQ_NUM-1:0] out_ready;
   logic [DATA_W-1:0]  out_data;

   modport master (
      output grant, grant_fire, rsp_valid, rsp_data, out_ready,
      input  id_full, rsp_ready, out_valid, out_data
   );

   modport slave (
      input  grant, grant_fire, rsp_valid, rsp_data, out_ready,
      output id_full, rsp_ready, out_valid, out_data
   );
endinterface

// File: rtl/rr_rsp_router.sv
// Records the arbiter winner for each accepted transaction in an ID FIFO and steers
// in-order responses from the shared resource back to the requester that issued them.
module rr_rsp_router #(
   parameter int REQ_NUM = 7,
   parameter int DEPTH   = 4,
   parameter int DATA_W  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   rr_rsp_router_if.slave         bus,
   output logic [$clog2(DEPTH):0] outstanding,
   output logic                   err_ovf,
   output logic                   err_orphan,
   output logic                   err_grant,
   input  logic                   err_clr
);

   localparam int W  = $clog2(REQ_NUM);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [W-1:0]  head;
   logic [W-1:0]  grant_idx;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          grant_multi;
   logic          rsp_ready_c;
   logic          ovf_evt;
   logic          orphan_evt;
   logic          grant_evt;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_comb begin
      grant_idx = '0;
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
         if (bus.grant[k]) grant_idx = W'(k);
      end
   end

   assign grant_multi = |(bus.grant & (bus.grant - REQ_NUM'(1)));

   // out_valid is built from head and rsp_valid only, never from out_ready.
   always_comb begin
      bus.out_valid = '0;
      rsp_ready_c   = 1'b0;
      for (int k = 0; k < REQ_NUM; k++) begin
         if (head == W'(k)) begin
            bus.out_valid[k] = bus.rsp_valid & ~empty;
            rsp_ready_c      = ~empty & bus.out_ready[k];
         end
      end
   end

   assign bus.rsp_ready = rsp_ready_c;
   assign bus.out_data  = bus.rsp_data;
   assign bus.id_full   = full;

   assign pop  = bus.rsp_valid & rsp_ready_c;
   assign push = bus.grant_fire & (|bus.grant) & (~full | pop);

   assign ovf_evt    = bus.grant_fire & full & ~pop;
   assign orphan_evt = bus.rsp_valid & empty & ~push;
   assign grant_evt  = bus.grant_fire & (~(|bus.grant) | grant_multi);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= grant_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   outstanding <= outstanding + PW'(1);
            2'b01:   outstanding <= outstanding - PW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // A new error event in the clearing cycle keeps its flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ovf    <= 1'b0;
         err_orphan <= 1'b0;
         err_grant  <= 1'b0;
      end else begin
         err_ovf    <= ovf_evt    | (err_ovf    & ~err_clr);
         err_orphan <= orphan_evt | (err_orphan & ~err_clr);
         err_grant  <= grant_evt  | (err_grant  & ~err_clr);
      end
   end

endmodule

// File: tb/tb_rr_rsp_router.sv
// Bench for rr_rsp_router: table of per-cycle vectors with hand expectations, a queue
// model of outstanding IDs as scoreboard, and hand sequences for errors and reset.
module tb_rr_rsp_router;

   localparam int REQ_NUM = 7;
   localparam int DEPTH   = 4;
   localparam int DATA_W  = 32;
   localparam int PW      = $clog2(DEPTH) + 1;
   localparam logic [6:0] ALL = 7'h7F;
   localparam logic [6:0] BP  = 7'b1111011;

   typedef struct {
      logic [6:0]  grant;
      logic        fire;
      logic        rv;
      logic [31:0] data;
      logic [6:0]  ordy;
      logic        clr;
      logic [6:0]  ev;
      logic        er;
      int          eo;
      logic        ef;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rr_rsp_router_if #(.REQ_NUM(REQ_NUM), .DATA_W(DATA_W)) bus ();

   logic [PW-1:0] outstanding;
   logic          err_ovf;
   logic          err_orphan;
   logic          err_grant;
   logic          err_clr;

   rr_rsp_router #(.REQ_NUM(REQ_NUM), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .outstanding (outstanding),
      .err_ovf     (err_ovf),
      .err_orphan  (err_orphan),
      .err_grant   (err_grant),
      .err_clr     (err_clr)
   );

   int vec_cnt  = 0;
   int fail_cnt = 0;
   int q[$];
   bit m_ovf, m_orph, m_grant;
   vec_t tbl[30];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [6:0] grant, input logic fire, input logic rv,
                               input logic [31:0] data, input logic [6:0] ordy, input logic clr,
                               input logic [6:0] ev, input logic er, input int eo, input logic ef);
      vec_t v;
      v.grant = grant; v.fire = fire; v.rv = rv; v.data = data; v.ordy = ordy;
      v.clr = clr; v.ev = ev; v.er = er; v.eo = eo; v.ef = ef;
      return v;
   endfunction

   function automatic vec_t idle();
      return mk(7'd0, 1'b0, 1'b0, 32'd0, ALL, 1'b0, 7'd0, 1'b0, 0, 1'b0);
   endfunction

   // Drive one cycle, compare against the queue model (and the table row if hand=1),
   // then advance the model to what the coming clock edge should do.
   task automatic step(input vec_t v, input bit hand);
      logic [6:0] exp_ov;
      logic       exp_rr;
      bit         pop, push, ovf, orph, gerr;
      int         idx;
      @(negedge clk);
      bus.grant      = v.grant;
      bus.grant_fire = v.fire;
      bus.rsp_valid  = v.rv;
      bus.rsp_data   = v.data;
      bus.out_ready  = v.ordy;
      err_clr        = v.clr;
      #2;
      exp_ov = (v.rv && q.size() > 0) ? (7'd1 << q[0]) : 7'd0;
      exp_rr = (q.size() > 0) && v.ordy[q[0]];
      chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
      chk("rsp_ready", 64'(bus.rsp_ready), 64'(exp_rr));
      chk("outstanding", 64'(outstanding), 64'(q.size()));
      chk("id_full", 64'(bus.id_full), 64'(q.size() == DEPTH));
      if (exp_ov != 7'd0) chk("out_data", 64'(bus.out_data), 64'(v.data));
      chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
      chk("err_orphan", 64'(err_orphan), 64'(m_orph));
      chk("err_grant", 64'(err_grant), 64'(m_grant));
      if (hand) begin
         chk("tbl_out_valid", 64'(bus.out_valid), 64'(v.ev));
         chk("tbl_rsp_ready", 64'(bus.rsp_ready), 64'(v.er));
         chk("tbl_outstanding", 64'(outstanding), 64'(v.eo));
         chk("tbl_id_full", 64'(bus.id_full), 64'(v.ef));
      end
      pop  = v.rv && exp_rr;
      push = v.fire && (v.grant != 7'd0) && (q.size() < DEPTH || pop);
      ovf  = v.fire && (q.size() == DEPTH) && !pop;
      orph = v.rv && (q.size() == 0) && !push;
      gerr = v.fire && ((v.grant == 7'd0) || ((v.grant & (v.grant - 7'd1)) != 7'd0));
      idx = 0;
      for (int k = REQ_NUM - 1; k >= 0; k--) if (v.grant[k]) idx = k;
      m_ovf   = ovf  || (m_ovf   && !v.clr);
      m_orph  = orph || (m_orph  && !v.clr);
      m_grant = gerr || (m_grant && !v.clr);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(idx);
   endtask

   initial begin
      bus.grant = '0; bus.grant_fire = 1'b0; bus.rsp_valid = 1'b0;
      bus.rsp_data = '0; bus.out_ready = '0; err_clr = 1'b0;

      // single transaction
      tbl[0]  = mk(7'b0000100, 1, 0, 32'h0,         ALL, 0, 7'b0000000, 0, 0, 0);
      tbl[1]  = mk(7'b0000000, 0, 1, 32'hA5A5_0001, ALL, 0, 7'b0000100, 1, 1, 0);
      tbl[2]  = mk(7'b0000000, 0, 0, 32'h0,         ALL, 0, 7'b0000000, 0, 0, 0);
      // in-order routing 6,0,3,3
      tbl[3]  = mk(7'b1000000, 1, 0, 32'h0,  ALL, 0, 7'b0000000, 0, 0, 0);
      tbl[4]  = mk(7'b0000001, 1, 0, 32'h0,  ALL, 0, 7'b0000000, 1, 1, 0);
      tbl[5]  = mk(7'b0001000, 1, 0, 32'h0,  ALL, 0, 7'b0000000, 1, 2, 0);
      tbl[6]  = mk(7'b0001000, 1, 0, 32'h0,  ALL, 0, 7'b0000000, 1, 3, 0);
      tbl[7]  = mk(7'b0000000, 0, 1, 32'h10, ALL, 0, 7'b1000000, 1, 4, 1);
      tbl[8]  = mk(7'b0000000, 0, 1, 32'h11, ALL, 0, 7'b0000001, 1, 3, 0);
      tbl[9]  = mk(7'b0000000, 0, 1, 32'h12, ALL, 0, 7'b0001000, 1, 2, 0);
      tbl[10] = mk(7'b0000000, 0, 1, 32'h13, ALL, 0, 7'b0001000, 1, 1, 0);
      tbl[11] = mk(7'b0000000, 0, 0, 32'h0,  ALL, 0, 7'b0000000, 0, 0, 0);
      // fill with 1,2,4,5 then overflow attempt with 6
      tbl[12] = mk(7'b0000010, 1, 0, 32'h0, ALL, 0, 7'b0000000, 0, 0, 0);
      tbl[13] = mk(7'b0000100, 1, 0, 32'h0, ALL, 0, 7'b0000000, 1, 1, 0);
      tbl[14] = mk(7'b0010000, 1, 0, 32'h0, ALL, 0, 7'b0000000, 1, 2, 0);
      tbl[15] = mk(7'b0100000, 1, 0, 32'h0, ALL, 0, 7'b0000000, 1, 3, 0);
      tbl[16] = mk(7'b1000000, 1, 0, 32'h0, ALL, 0, 7'b0000000, 1, 4, 1);
      tbl[17] = mk(7'b0000000, 0, 0, 32'h0, ALL, 0, 7'b0000000, 1, 4, 1);
      // full: pop 1 while pushing 5, then drain 2,4,5,5
      tbl[18] = mk(7'b0100000, 1, 1, 32'h20, ALL, 0, 7'b0000010, 1, 4, 1);
      tbl[19] = mk(7'b0000000, 0, 1, 32'h21, ALL, 0, 7'b0000100, 1, 4, 1);
      tbl[20] = mk(7'b0000000, 0, 1, 32'h22, ALL, 0, 7'b0010000, 1, 3, 0);
      tbl[21] = mk(7'b0000000, 0, 1, 32'h23, ALL, 0, 7'b0100000, 1, 2, 0);
      tbl[22] = mk(7'b0000000, 0, 1, 32'h24, ALL, 0, 7'b0100000, 1, 1, 0);
      tbl[23] = mk(7'b0000000, 0, 0, 32'h0,  ALL, 0, 7'b0000000, 0, 0, 0);
      // backpressure on index 2 for three cycles
      tbl[24] = mk(7'b0000100, 1, 0, 32'h0,  ALL, 0, 7'b0000000, 0, 0, 0);
      tbl[25] = mk(7'b0000000, 0, 1, 32'h30, BP,  0, 7'b0000100, 0, 1, 0);
      tbl[26] = mk(7'b0000000, 0, 1, 32'h30, BP,  0, 7'b0000100, 0, 1, 0);
      tbl[27] = mk(7'b0000000, 0, 1, 32'h30, BP,  0, 7'b0000100, 0, 1, 0);
      tbl[28] = mk(7'b0000000, 0, 1, 32'h30, ALL, 0, 7'b0000100, 1, 1, 0);
      tbl[29] = mk(7'b0000000, 0, 0, 32'h0,  ALL, 0, 7'b0000000, 0, 0, 0);

      #12;
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_rsp_ready", 64'(bus.rsp_ready), 64'd0);
      chk("rst_id_full", 64'(bus.id_full), 64'd0);
      chk("rst_errs", 64'({err_ovf, err_orphan, err_grant}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++) step(tbl[i], 1'b1);

      // orphan response while empty
      step(mk(7'd0, 0, 1, 32'hDEAD, ALL, 0, 7'd0, 0, 0, 0), 1'b1);
      @(posedge clk); #1;
      chk("orphan_set", 64'(err_orphan), 64'd1);
      chk("ovf_still_set", 64'(err_ovf), 64'd1);

      // multi-hot grant pushes the lowest index
      step(mk(7'b0001010, 1, 0, 32'h0, ALL, 0, 7'd0, 0, 0, 0), 1'b1);
      @(posedge clk); #1;
      chk("grant_err_set", 64'(err_grant), 64'd1);
      step(mk(7'd0, 0, 1, 32'h40, ALL, 0, 7'b0000010, 1, 1, 0), 1'b1);

      // clear in the same cycle as a fresh orphan event: orphan survives
      step(mk(7'd0, 0, 1, 32'h0, ALL, 1, 7'd0, 0, 0, 0), 1'b1);
      @(posedge clk); #1;
      chk("clr_orphan_wins", 64'(err_orphan), 64'd1);
      chk("clr_ovf", 64'(err_ovf), 64'd0);
      chk("clr_grant", 64'(err_grant), 64'd0);
      step(mk(7'd0, 0, 0, 32'h0, ALL, 1, 7'd0, 0, 0, 0), 1'b1);
      @(posedge clk); #1;
      chk("clr_all", 64'({err_ovf, err_orphan, err_grant}), 64'd0);

      // reset with two outstanding while a response is being offered
      step(mk(7'b0001000, 1, 0, 32'h0, ALL, 0, 7'd0, 0, 0, 0), 1'b1);
      step(mk(7'b1000000, 1, 0, 32'h0, ALL, 0, 7'd0, 1, 1, 0), 1'b1);
      @(negedge clk);
      bus.grant = '0; bus.grant_fire = 1'b0; bus.rsp_valid = 1'b1;
      bus.rsp_data = 32'h55; bus.out_ready = ALL;
      #1;
      chk("pre_rst_out_valid", 64'(bus.out_valid), 64'(7'b0001000));
      chk("pre_rst_outstanding", 64'(outstanding), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("async_rst_outstanding", 64'(outstanding), 64'd0);
      chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_rst_rsp_ready", 64'(bus.rsp_ready), 64'd0);
      q.delete();
      m_ovf = 0; m_orph = 0; m_grant = 0;
      bus.rsp_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(idle(), 1'b1);
      step(mk(7'b0000001, 1, 0, 32'h0, ALL, 0, 7'd0, 0, 0, 0), 1'b1);
      step(mk(7'd0, 0, 1, 32'h77, ALL, 0, 7'b0000001, 1, 1, 0), 1'b1);
      step(idle(), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
      $finish;
   end

endmodule
